// File: rtl/noc_arb_pkg.sv
//------------------------------------------------------------------------------
// noc_arb_pkg : shared types and index helpers for NoC arbiters
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package noc_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } rr_arb_state_e;

    localparam int ARB_MAX_N = 64;
    localparam int ARB_MAX_W = 6;

    // Helpers take the live width so callers can ignore bits above it.
    function automatic logic [ARB_MAX_W-1:0] onehot2bin(input logic [ARB_MAX_N-1:0] oh,
                                                        input int width);
        logic [ARB_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (i < width && oh[i]) begin
                idx = idx | ARB_MAX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [ARB_MAX_N-1:0] bin2onehot(input logic [ARB_MAX_W-1:0] idx,
                                                        input int width);
        logic [ARB_MAX_N-1:0] oh;
        oh = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (i < width && idx == ARB_MAX_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/left_circular_rotate.sv
//------------------------------------------------------------------------------
// left_circular_rotate : rotate a vector left by a runtime amount (mod WIDTH)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module left_circular_rotate #(
    parameter int WIDTH       = 4,
    parameter int SHIFT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]       data_in,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [WIDTH-1:0]       data_out
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    int src;

    // data_out[j] takes data_in[(j - shift) mod WIDTH]
    always_comb begin
        data_out = '0;
        src      = 0;
        for (int j = 0; j < WIDTH; j++) begin
            src         = (j + WIDTH - (int'(shift) % WIDTH)) % WIDTH;
            data_out[j] = data_in[IW'(src)];
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_pkt_arbiter.sv
//------------------------------------------------------------------------------
// rr_pkt_arbiter : packet-granular round-robin arbiter with valid/ready output
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pkt_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N_INPUT = 4,
    localparam int N_INPUT_WIDTH = (N_INPUT > 1) ? $clog2(N_INPUT) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_INPUT-1:0]       req_i,
    input  logic [N_INPUT-1:0]       tail_i,
    input  logic                     gnt_rdy_i,
    output logic                     gnt_vld_o,
    output logic [N_INPUT-1:0]       gnt_o,
    output logic [N_INPUT_WIDTH-1:0] gnt_idx_o
);

    localparam int             PW     = N_INPUT_WIDTH + 1;
    localparam logic [PW-1:0]  N_WIDE = PW'(N_INPUT);

    // Operands are always below 2*N_INPUT, so one conditional subtract suffices.
    function automatic logic [N_INPUT_WIDTH-1:0] mod_n(input logic [PW-1:0] v);
        return (v >= N_WIDE) ? N_INPUT_WIDTH'(v - N_WIDE) : N_INPUT_WIDTH'(v);
    endfunction

    rr_arb_state_e            state;
    logic [N_INPUT_WIDTH-1:0] ptr;
    logic [N_INPUT_WIDTH-1:0] owner;

    logic [N_INPUT_WIDTH-1:0] shift;
    logic [N_INPUT-1:0]       rot;
    logic [N_INPUT_WIDTH-1:0] lsb;
    logic [N_INPUT_WIDTH-1:0] winner;
    logic [N_INPUT_WIDTH-1:0] sel;
    logic                     locked;
    logic                     show;

    assign shift = mod_n(N_WIDE - {1'b0, ptr});

    left_circular_rotate #(
        .WIDTH       (N_INPUT),
        .SHIFT_WIDTH (N_INPUT_WIDTH)
    ) u_rot (
        .data_in  (req_i),
        .shift    (shift),
        .data_out (rot)
    );

    always_comb begin
        lsb = '0;
        for (int j = N_INPUT - 1; j >= 0; j--) begin
            if (rot[j]) begin
                lsb = N_INPUT_WIDTH'(j);
            end
        end
    end

    assign winner = mod_n({1'b0, ptr} + {1'b0, lsb});
    assign locked = (state == LOCK);
    assign sel    = locked ? owner : winner;
    assign show   = locked | (|req_i);

    // While locked the grant is pinned to the owner even through bubbles.
    assign gnt_vld_o = locked ? req_i[owner] : (|req_i);
    assign gnt_idx_o = show ? sel : '0;

    always_comb begin
        gnt_o = '0;
        for (int j = 0; j < N_INPUT; j++) begin
            gnt_o[j] = show && (sel == N_INPUT_WIDTH'(j));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (|req_i) begin
                        if (gnt_rdy_i && tail_i[winner]) begin
                            ptr <= mod_n({1'b0, winner} + PW'(1));
                        end else begin
                            state <= LOCK;
                            owner <= winner;
                        end
                    end
                end
                LOCK: begin
                    if (req_i[owner] && gnt_rdy_i && tail_i[owner]) begin
                        state <= ARB;
                        ptr   <= mod_n({1'b0, owner} + PW'(1));
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

`default_nettype wire
